// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg
// Shared types and helpers for the load/store unit.
//   lsu_size_t   : request size encoding (byte, half, word; 2'b11 acts as word)
//   lsu_state_t  : FSM state encoding for the unit
//   is_word      : true for word-sized requests (both word encodings)
//   is_misaligned: half with addr[0]=1, or word with addr[1:0]!=0
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } lsu_size_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_READ    = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_WRITE   = 2'b11
    } lsu_state_t;

    localparam int unsigned LSU_XLEN = 32;

    // Both 2'b10 and 2'b11 are word accesses, so only the upper bit matters.
    function automatic logic is_word(input lsu_size_t size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] offset);
        return ((size == SIZE_HALF) && offset[0]) || (is_word(size) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align
// Combinational lane logic for the load/store unit.
//   offset      in  2   byte offset within the word (addr[1:0])
//   size        in  2   access size (lsu_size_t)
//   is_unsigned in  1   zero-extend sub-word loads
//   mem_word    in  32  word read from memory
//   store_data  in  32  right-justified store data
//   load_data   out 32  extracted and extended load value
//   merge_data  out 32  memory word with the store lane replaced
// Half accesses look only at offset[1], so an odd half offset is aligned down.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  lsu_size_t   size,
    input  logic        is_unsigned,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = mem_word[{offset, 3'b000} +: 8];
        lane_half = offset[1] ? mem_word[31:16] : mem_word[15:0];

        load_data  = mem_word;
        merge_data = mem_word;
        case (size)
            SIZE_BYTE: begin
                load_data = is_unsigned ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
                merge_data[{offset, 3'b000} +: 8] = store_data[7:0];
            end
            SIZE_HALF: begin
                load_data = is_unsigned ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
                merge_data[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            end
            default: begin
                load_data  = mem_word;
                merge_data = store_data;
            end
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu
// Load/store unit between the datapath and a word-only synchronous memory.
// Sub-word stores are done as read-modify-write.
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake (transfer when both high;
//                             req_ready is high only in IDLE)
//   req_write, req_size, req_unsigned, req_addr, req_wdata  request fields
//   rsp_valid                 one-cycle completion pulse
//   rsp_rdata                 extended load data, 0 for stores
//   rsp_error                 misaligned access (only with the macro)
//   dAddress, MemWrite, dWriteData, dReadData  memory port
// Optional feature macro: LSU_MISALIGN_CHECK_EN -- misaligned half/word
// requests are rejected with rsp_error instead of being aligned down.
module riscv_lsu
    import riscv_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] dAddress,
    output logic        MemWrite,
    output logic [31:0] dWriteData,
    input  logic [31:0] dReadData
);

    lsu_state_t  state;
    logic        wr_q;
    lsu_size_t   size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    lsu_size_t   req_sz;
    logic        accept;
    logic        misaligned;

    assign req_sz = lsu_size_t'(req_size);
    assign accept = req_valid && req_ready;

    // Decoded from the state register so reset clears MemWrite immediately.
    assign req_ready = (state == ST_IDLE);
    assign MemWrite  = (state == ST_WRITE);

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q;
    assign misaligned = is_misaligned(req_sz, req_addr[1:0]);
    assign rsp_error  = err_q;
`else
    assign misaligned = 1'b0;
    assign rsp_error  = 1'b0;
`endif

    riscv_lsu_align u_align (
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .mem_word    (dReadData),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= 32'h0;
            dAddress   <= 32'h0;
            dWriteData <= 32'h0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wr_q    <= req_write;
                        size_q  <= req_sz;
                        uns_q   <= req_unsigned;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (misaligned) begin
                            // Rejected without touching the memory port.
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
                            err_q     <= 1'b1;
`endif
                        end else begin
                            dAddress <= {req_addr[31:2], 2'b00};
                            if (req_write && is_word(req_sz)) begin
                                dWriteData <= req_wdata;
                                state      <= ST_WRITE;
                            end else begin
                                state <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (wr_q) begin
                        dWriteData <= merge_data;
                        state      <= ST_WRITE;
                    end else begin
                        rsp_rdata <= load_data;
                        rsp_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    rsp_rdata <= 32'h0;
                    rsp_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu
// Self-checking bench for riscv_lsu with a word memory model, a reference
// memory image and a behavioural model of loads, stores and latencies.
// Honours LSU_MISALIGN_CHECK_EN the same way the design does.
module tb_riscv_lsu;

    localparam logic [31:0] BASE = 32'h0080_0000;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] dAddress;
    logic        MemWrite;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;

    riscv_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .dAddress     (dAddress),
        .MemWrite     (MemWrite),
        .dWriteData   (dWriteData),
        .dReadData    (dReadData)
    );

    // synchronous word memory: read data valid the cycle after the address
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        dReadData <= mem[dAddress[9:2]];
        if (MemWrite) mem[dAddress[9:2]] <= dWriteData;
    end

    // reference model state and scoreboard
    logic [31:0] ref_mem [0:255];
    logic [31:0] last_daddr = 32'h0;
    logic [31:0] exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input int sz,
                                               input bit uns, input int off);
        logic [31:0] v;
        if (sz == 0) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (word >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] word, input int sz,
                                                input int off, input logic [31:0] wdata);
        logic [31:0] mask;
        int sh;
        if (sz == 0) begin
            sh = 8 * off;
            mask = 32'hFF << sh;
            return (word & ~mask) | ((wdata & 32'hFF) << sh);
        end else if (sz == 1) begin
            sh = (off >= 2) ? 16 : 0;
            mask = 32'hFFFF << sh;
            return (word & ~mask) | ((wdata & 32'hFFFF) << sh);
        end
        return wdata;
    endfunction

    // driver: call at a negedge; returns at the negedge of the response cycle
    task automatic do_req(input string tag, input bit wr, input int sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got_rdata);
        int off;
        int idx;
        bit exp_err;
        int exp_lat;
        int exp_mw_n;
        int exp_mw_cyc;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_daddr;
        int mw_n;
        int mw_cyc;
        logic [31:0] mw_data;
        logic [31:0] mw_addr;
        int rsp_cyc;
        bit got;

        off = int'(addr[1:0]);
        idx = int'(addr[9:2]);
`ifdef LSU_MISALIGN_CHECK_EN
        exp_err = (sz == 1 && (off % 2) == 1) || (sz >= 2 && off != 0);
`else
        exp_err = 1'b0;
`endif
        exp_mw_n = 0;
        exp_mw_cyc = 0;
        exp_wdata = 32'h0;
        exp_rdata = 32'h0;
        if (exp_err) begin
            exp_lat = 1;
            exp_daddr = last_daddr;
        end else begin
            exp_daddr = addr & 32'hFFFF_FFFC;
            last_daddr = exp_daddr;
            if (!wr) begin
                exp_lat = 3;
                exp_rdata = model_load(ref_mem[idx], sz, uns, off);
            end else begin
                exp_mw_n = 1;
                exp_wdata = model_merge(ref_mem[idx], sz, off, wdata);
                exp_lat = (sz >= 2) ? 2 : 4;
                exp_mw_cyc = exp_lat - 1;
                ref_mem[idx] = exp_wdata;
            end
        end
        exp_q.push_back(exp_rdata);

        req_valid = 1'b1;
        req_write = wr;
        req_size = 2'(sz);
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;

        mw_n = 0;
        mw_cyc = 0;
        mw_data = 32'h0;
        mw_addr = 32'h0;
        rsp_cyc = 0;
        got = 1'b0;
        got_rdata = 32'h0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (MemWrite) begin
                mw_n++;
                mw_cyc = cyc;
                mw_data = dWriteData;
                mw_addr = dAddress;
            end
            if (rsp_valid) begin
                rsp_cyc = cyc;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
            return;
        end
        got_rdata = rsp_rdata;
        check({tag, "_lat"}, rsp_cyc, exp_lat);
        check({tag, "_rdata"}, rsp_rdata, exp_q.pop_front());
        check({tag, "_err"}, rsp_error, exp_err);
        check({tag, "_mw_n"}, mw_n, exp_mw_n);
        if (exp_mw_n != 0) begin
            check({tag, "_mw_cyc"}, mw_cyc, exp_mw_cyc);
            check({tag, "_mw_data"}, mw_data, exp_wdata);
            check({tag, "_mw_addr"}, mw_addr, exp_daddr);
        end
        check({tag, "_daddr"}, dAddress, exp_daddr);
        check({tag, "_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] r;
        bit seen;
        int mism;

        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[1] = 32'h8899_AABB;
        ref_mem[1] = 32'h8899_AABB;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_error", rsp_error, 1'b0);
        check("rst_memwrite", MemWrite, 1'b0);
        check("rst_daddr", dAddress, 32'h0);
        check("rst_dwdata", dWriteData, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        do_req("t1_lb", 1'b0, 0, 1'b0, BASE + 32'h5, 32'h0, r);
        check("t1_value", r, 32'hFFFF_FFAA);
        do_req("t2_lhu", 1'b0, 1, 1'b1, BASE + 32'h6, 32'h0, r);
        check("t2_value_u", r, 32'h0000_8899);
        do_req("t2_lh", 1'b0, 1, 1'b0, BASE + 32'h6, 32'h0, r);
        check("t2_value_s", r, 32'hFFFF_8899);
        do_req("t3_sb", 1'b1, 0, 1'b0, BASE + 32'h7, 32'h12, r);
        do_req("t3_lw", 1'b0, 2, 1'b0, BASE + 32'h4, 32'h0, r);
        check("t3_value", r, 32'h1299_AABB);
        do_req("t4_sw", 1'b1, 2, 1'b0, BASE + 32'h8, 32'hDEAD_BEEF, r);
        do_req("t4_lw", 1'b0, 2, 1'b0, BASE + 32'h8, 32'h0, r);
        check("t4_value", r, 32'hDEAD_BEEF);
        do_req("t5_lw_mis", 1'b0, 2, 1'b0, BASE + 32'h2, 32'h0, r);
        do_req("t5_sh_mis", 1'b1, 1, 1'b0, BASE + 32'h11, 32'h0000_7777, r);

        // reset during the WRITE state of a byte store
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = BASE + 32'h4;
        req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (MemWrite) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_reach_write", seen, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("t6_memwrite_drop", MemWrite, 1'b0);
        check("t6_ready_in_rst", req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        last_daddr = 32'h0;
        @(negedge clk);
        check("t6_ready_after", req_ready, 1'b1);
        check("t6_no_rsp", rsp_valid, 1'b0);
        do_req("t6_lw", 1'b0, 2, 1'b0, BASE + 32'h4, 32'h0, r);
        check("t6_value", r, 32'h1299_AABB);

        // randomized traffic
        for (int n = 0; n < 120; n++) begin
            do_req("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 1023)),
                   $urandom, r);
        end

        // memory image must match the reference after all traffic
        @(negedge clk);
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("mem_image", mism, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
